// File: rtl/i2s_pkg.sv
// Shared frame-timing constants for the I2S stream transmitter.
// The load bit carries the one-SClk I2S data delay after each word-select change.
package i2s_pkg;

    localparam int LOAD_BIT = 1;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

    function automatic int half_period(input int sclk_div);
        return sclk_div / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and a registered occupancy count.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2s_stream_tx.sv
// I2S transmitter: buffers stereo frames in a FIFO and shifts them out MSB-first
// with the standard one-bit delay after each LRClk change.
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int SLOT_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int SCLK_DIV  = 16,
    parameter int LOW_WATER = 256
) (
    input  logic                   Clk50,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   mute,
    input  logic [2*DATA_W-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   SClk,
    output logic                   LRClk,
    output logic                   Dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   refill_req,
    output logic                   underrun,
    input  logic                   underrun_clr
);
    localparam int FRAME = frame_bits(SLOT_W);
    localparam int B_W   = $clog2(FRAME);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(half_period(SCLK_DIV));
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
    localparam logic [B_W-1:0]   B_LOAD   = B_W'(LOAD_BIT);
    localparam logic [B_W-1:0]   B_RIGHT  = B_W'(SLOT_W);
    localparam logic [B_W-1:0]   B_ONE    = B_W'(1);
    localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WATER);

    logic [DIV_W-1:0]    div;
    logic [DIV_W-1:0]    div_next;
    logic [B_W-1:0]      b;
    logic [B_W-1:0]      b_next;
    logic [FRAME-1:0]    sr;
    logic [FRAME-1:0]    load_word;
    logic                sclk_q;
    logic                lrclk_q;
    logic                underrun_q;
    logic                fall;
    logic                load;
    logic                pop;
    logic                push;
    logic                fifo_empty;
    logic                fifo_full;
    logic [2*DATA_W-1:0] fifo_data;

    // Handshake: a frame transfers on any Clk50 edge where in_valid && in_ready;
    // in_valid may be held or dropped freely, in_ready is low only while full or in reset.
    assign in_ready   = !reset && !fifo_full;
    assign push       = in_valid && in_ready;
    assign refill_req = (level <= LVL_LOW);
    assign SClk       = sclk_q;
    assign LRClk      = lrclk_q;
    assign Dout       = sr[FRAME-1];
    assign underrun   = underrun_q;

    always_comb begin
        div_next  = (div == DIV_LAST) ? '0 : div + DIV_ONE;
        b_next    = (b == B_LAST) ? '0 : b + B_ONE;
        fall      = enable && (div == DIV_LAST);
        load      = fall && (b_next == B_LOAD);
        pop       = load && !fifo_empty;
        load_word = '0;
        // Each channel is left-justified in its slot; muted or missing frames stay zero.
        if (pop && !mute) begin
            load_word[FRAME-1 -: DATA_W]  = fifo_data[2*DATA_W-1 -: DATA_W];
            load_word[SLOT_W-1 -: DATA_W] = fifo_data[DATA_W-1:0];
        end
    end

    always_ff @(posedge Clk50) begin
        if (reset || !enable) begin
            div     <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            b       <= '0;
            sr      <= '0;
        end else begin
            div    <= div_next;
            sclk_q <= (div_next >= DIV_HALF);
            if (fall) begin
                b       <= b_next;
                lrclk_q <= (b_next >= B_RIGHT);
                sr      <= load ? load_word : {sr[FRAME-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge Clk50) begin
        if (reset) begin
            underrun_q <= 1'b0;
        end else if (load && fifo_empty) begin
            underrun_q <= 1'b1;
        end else if (underrun_clr) begin
            underrun_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clk50),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (level)
    );

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed bench for i2s_stream_tx: three configurations (defaults, 16-bit slots,
// 4-deep FIFO) checked against an expected-bit queue and register expectations.
module tb_i2s_stream_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: default parameters
    logic        a_enable = 0, a_mute = 0, a_in_valid = 0, a_underrun_clr = 0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_sclk, a_lrclk, a_dout, a_refill, a_underrun;
    logic [10:0] a_level;

    // Instance B: DATA_W = SLOT_W = 16
    logic        b_enable = 0, b_mute = 0, b_in_valid = 0, b_underrun_clr = 0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_sclk, b_lrclk, b_dout, b_refill, b_underrun;
    logic [4:0]  b_level;

    // Instance C: DEPTH = 4, LOW_WATER = 2
    logic        c_enable = 0, c_mute = 0, c_in_valid = 0, c_underrun_clr = 0;
    logic [31:0] c_in_data = '0;
    logic        c_in_ready, c_sclk, c_lrclk, c_dout, c_refill, c_underrun;
    logic [2:0]  c_level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_b_q[$];

    always #10 clk = ~clk;

    i2s_stream_tx dut_a (
        .Clk50(clk), .reset(rst), .enable(a_enable), .mute(a_mute),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .SClk(a_sclk), .LRClk(a_lrclk), .Dout(a_dout), .level(a_level),
        .refill_req(a_refill), .underrun(a_underrun), .underrun_clr(a_underrun_clr)
    );

    i2s_stream_tx #(.DATA_W(16), .SLOT_W(16), .DEPTH(16), .SCLK_DIV(4), .LOW_WATER(4)) dut_b (
        .Clk50(clk), .reset(rst), .enable(b_enable), .mute(b_mute),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .SClk(b_sclk), .LRClk(b_lrclk), .Dout(b_dout), .level(b_level),
        .refill_req(b_refill), .underrun(b_underrun), .underrun_clr(b_underrun_clr)
    );

    i2s_stream_tx #(.DEPTH(4), .LOW_WATER(2)) dut_c (
        .Clk50(clk), .reset(rst), .enable(c_enable), .mute(c_mute),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .SClk(c_sclk), .LRClk(c_lrclk), .Dout(c_dout), .level(c_level),
        .refill_req(c_refill), .underrun(c_underrun), .underrun_clr(c_underrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected Dout for 16-bit data in 32-bit slots, bit index b of a frame.
    function automatic logic exp_bit32(input logic [15:0] l, input logic [15:0] r, input int b);
        if (b >= 1 && b <= 16) return l[16-b];
        if (b >= 33 && b <= 48) return r[48-b];
        return 1'b0;
    endfunction

    task automatic sb_frame_a(input logic [15:0] l, input logic [15:0] r, input bit muted);
        for (int b = 0; b < 64; b++)
            exp_q.push_back({(b >= 32), muted ? 1'b0 : exp_bit32(l, r, b)});
    endtask

    // Waits for the next SClk 0->1 transition of instance A (0) or B (1), sampled on negedges.
    task automatic wait_rise(input int which);
        logic prev, cur;
        bit   seen;
        seen = 0;
        prev = (which == 1) ? b_sclk : a_sclk;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            cur = (which == 1) ? b_sclk : a_sclk;
            if (!prev && cur) seen = 1;
            prev = cur;
        end
        if (!seen) check("sclk_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_frame(input int which, input logic [31:0] d);
        @(negedge clk);
        if (which == 1) begin
            check("push_ready_b", 32'(b_in_ready), 32'd1);
            b_in_data  = d;
            b_in_valid = 1;
        end else begin
            check("push_ready_a", 32'(a_in_ready), 32'd1);
            a_in_data  = d;
            a_in_valid = 1;
        end
        @(negedge clk);
        a_in_valid = 0;
        b_in_valid = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(a_in_ready), 32'd0);
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", 32'(a_in_ready), 32'd1);
        check("reset_level", 32'(a_level), 32'd0);
        check("reset_pins", {29'd0, a_sclk, a_lrclk, a_dout}, 32'd0);
        check("reset_underrun", 32'(a_underrun), 32'd0);
        check("reset_refill", 32'(a_refill), 32'd1);

        // DEPTH=4 fill with enable low
        for (int i = 0; i < 5; i++) begin
            c_in_data  = 32'(i + 1);
            c_in_valid = 1;
            check($sformatf("c_ready_%0d", i), 32'(c_in_ready), 32'(i < 4));
            @(negedge clk);
        end
        c_in_valid = 0;
        check("c_full_level", 32'(c_level), 32'd4);
        check("c_full_refill", 32'(c_refill), 32'd0);
        check("c_full_ready", 32'(c_in_ready), 32'd0);

        // Enable with empty FIFO: underrun at first load, then cleared
        a_enable = 1;
        wait_rise(0);
        check("empty_b0_dout", 32'(a_dout), 32'd0);
        check("empty_b0_underrun", 32'(a_underrun), 32'd0);
        wait_rise(0);
        check("empty_b1_dout", 32'(a_dout), 32'd0);
        check("empty_b1_underrun", 32'(a_underrun), 32'd1);
        a_underrun_clr = 1;
        @(negedge clk);
        a_underrun_clr = 0;
        check("underrun_cleared", 32'(a_underrun), 32'd0);
        a_enable = 0;
        @(negedge clk);
        check("disabled_pins", {29'd0, a_sclk, a_lrclk, a_dout}, 32'd0);

        // One frame {A5A5, 0F0F}, full 64-bit frame against the scoreboard
        push_frame(0, {16'hA5A5, 16'h0F0F});
        sb_frame_a(16'hA5A5, 16'h0F0F, 0);
        check("frame_level_1", 32'(a_level), 32'd1);
        a_enable = 1;
        n = 0;
        while (!a_sclk && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("first_rise_delay", 32'(n), 32'd8);
        for (int i = 0; i < 64; i++) begin
            if (i > 0) wait_rise(0);
            e = exp_q.pop_front();
            check($sformatf("a_bit_%0d", i), {30'd0, a_lrclk, a_dout}, {30'd0, e});
            if (i == 1) check("frame_level_popped", 32'(a_level), 32'd0);
        end
        check("frame_underrun", 32'(a_underrun), 32'd0);
        check("frame_sb_drained", 32'(exp_q.size()), 32'd0);
        a_enable = 0;

        // Mute with two frames queued
        a_mute = 1;
        push_frame(0, 32'hFFFF_FFFF);
        push_frame(0, 32'hFFFF_FFFF);
        sb_frame_a(16'hFFFF, 16'hFFFF, 1);
        sb_frame_a(16'hFFFF, 16'hFFFF, 1);
        check("mute_level_2", 32'(a_level), 32'd2);
        a_enable = 1;
        for (int i = 0; i < 128; i++) begin
            wait_rise(0);
            e = exp_q.pop_front();
            check($sformatf("mute_bit_%0d", i), {30'd0, a_lrclk, a_dout}, {30'd0, e});
            if (i == 1)  check("mute_level_1", 32'(a_level), 32'd1);
            if (i == 65) check("mute_level_0", 32'(a_level), 32'd0);
        end
        check("mute_underrun", 32'(a_underrun), 32'd0);
        a_enable = 0;
        a_mute = 0;

        // Reset mid-frame at b=20 with three frames stored
        for (int k = 0; k < 3; k++) push_frame(0, 32'hFFFF_FFFF);
        check("pre_reset_level", 32'(a_level), 32'd3);
        for (int b = 0; b <= 20; b++)
            exp_q.push_back({1'b0, exp_bit32(16'hFFFF, 16'hFFFF, b)});
        a_enable = 1;
        for (int i = 0; i <= 20; i++) begin
            wait_rise(0);
            e = exp_q.pop_front();
            check($sformatf("pre_reset_bit_%0d", i), {30'd0, a_lrclk, a_dout}, {30'd0, e});
        end
        check("b20_sclk_high", 32'(a_sclk), 32'd1);
        check("b20_level", 32'(a_level), 32'd2);
        rst = 1;
        @(negedge clk);
        check("abort_pins", {29'd0, a_sclk, a_lrclk, a_dout}, 32'd0);
        check("abort_level", 32'(a_level), 32'd0);
        check("abort_ready", 32'(a_in_ready), 32'd0);
        a_enable = 0;
        rst = 0;
        @(negedge clk);

        // 16-bit slots: R LSB lands on b=0 of the following frame
        push_frame(1, {16'h8001, 16'h8001});
        push_frame(1, 32'h0000_0000);
        for (int i = 0; i < 65; i++) begin
            logic [15:0] v;
            int bb;
            v  = (i < 32) ? 16'h8001 : 16'h0000;
            bb = i % 32;
            if (bb >= 1 && bb <= 16)      exp_b_q.push_back({(bb >= 16), v[16-bb]});
            else if (bb >= 17)            exp_b_q.push_back({1'b1, v[32-bb]});
            else if (i == 32)             exp_b_q.push_back({1'b0, 1'b1});
            else                          exp_b_q.push_back(2'b00);
        end
        b_enable = 1;
        for (int i = 0; i < 65; i++) begin
            wait_rise(1);
            e = exp_b_q.pop_front();
            check($sformatf("b_bit_%0d", i), {30'd0, b_lrclk, b_dout}, {30'd0, e});
        end
        check("b_sb_drained", 32'(exp_b_q.size()), 32'd0);
        b_enable = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_stream_tx.md
I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

Interface
REQ-001 SHALL have parameter DATA_W, 16, sample bits per channel (8..32, <= SLOT_W).
REQ-002 SHALL have parameter SLOT_W, 32, SClk periods per channel slot (16..32).
REQ-003 SHALL have parameter DEPTH, 1024, FIFO depth in stereo frames (power of 2, >= 4).
REQ-004 SHALL have parameter SCLK_DIV, 16, Clk50 cycles per SClk period (even, >= 4).
REQ-005 SHALL have parameter LOW_WATER, 256, refill threshold in frames (< DEPTH).
REQ-006 SHALL have one clock and a synchronous active-high reset, with ports as listed below.
- Clk50  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run serial output.
- mute  in  1  transmit zeros; still consume frames.
- in_data  in  2*DATA_W  stereo frame {L,R}, L in upper half.
- in_valid  in  1  in_data valid.
- in_ready  out  1  frame accepted when in_valid && in_ready.
- SClk  out  1  bit clock.
- LRClk  out  1  word select (0 = left, 1 = right).
- Dout  out  1  serial data.
- level  out  $clog2(DEPTH)+1  frames stored.
- refill_req  out  1  level <= LOW_WATER.
- underrun  out  1  sticky empty-at-load flag.
- underrun_clr  in  1  clears underrun.

Function
REQ-007 SHALL generate SClk as a registered output: low for SCLK_DIV/2 Clk50 cycles, then high for SCLK_DIV/2, while enable=1.
REQ-008 SHALL keep a bit counter b, 0..2*SLOT_W-1, advanced at each SClk falling edge and wrapping to 0.
REQ-009 SHALL drive LRClk = (b >= SLOT_W), updated on the same Clk50 cycle as the SClk falling edge.
REQ-010 SHALL use a 2*SLOT_W shift register, Dout = MSB, shifted left with zero fill at every SClk falling edge, except on a load edge.
REQ-011 SHALL load the shift register with {L, zero pad to SLOT_W, R, zero pad to SLOT_W} at the falling edge entering b=1, giving the I2S one-bit delay; with DATA_W=SLOT_W the R LSB appears at b=0 of the next frame.
REQ-012 SHALL pop one FIFO frame in the same Clk50 cycle as the load.
REQ-013 SHALL, at a load with the FIFO empty, load all zeros, pop nothing, and set underrun.
REQ-014 SHALL, at a load with mute=1 and the FIFO non-empty, pop the frame and load zeros.
REQ-015 SHALL hold in_ready = !full; push when in_valid && in_ready; a simultaneous push and pop SHALL leave level unchanged.
REQ-016 SHALL register level; refill_req SHALL be combinational from level.
REQ-017 SHALL, while enable=0, hold SClk=0, LRClk=0, Dout=0, b=0 and the divider at 0; no pops occur and FIFO contents are retained.
REQ-018 SHALL, on enable rising, begin a frame at b=0 with the first SClk rising edge SCLK_DIV/2 cycles later.
REQ-019 SHALL clear underrun on underrun_clr unless a new underrun occurs in the same cycle, in which case set wins.

Reset
REQ-020 SHALL, on reset, set SClk=0, LRClk=0, Dout=0, b=0, divider=0, level=0, underrun=0, FIFO empty, shift register=0.
REQ-021 SHALL hold in_ready=0 while reset=1 and set in_ready=1 on the first cycle after reset.
REQ-022 SHALL, on reset mid-frame, abort the frame immediately and discard all stored frames.

Structure
REQ-023 SHALL place frame-timing constants and the load-bit index in shared package i2s_pkg.
REQ-024 SHALL instantiate sub-module sync_fifo (single-clock, width 2*DATA_W, depth DEPTH, registered count).

Verification
REQ-025 SHALL pass this test: defaults; push {16'hA5A5, 16'h0F0F}; enable. Dout bits 1-16 = A5A5 MSB-first; bits 33-48 = 0F0F; all other bits 0.
REQ-026 SHALL pass this test: DATA_W=SLOT_W=16; push {16'h8001, 16'h8001}, then {0,0}. The R LSB '1' appears at b=0 of the following frame.
REQ-027 SHALL pass this test: enable with an empty FIFO. Dout stays 0, underrun=1 after the first load (b=1); underrun_clr returns it to 0.
REQ-028 SHALL pass this test: DEPTH=4; push 5 frames with enable=0. in_ready=0 after 4 frames, level=4, refill_req=0 with LOW_WATER=2.
REQ-029 SHALL pass this test: mute=1 with 2 frames queued. Dout stays 0 and level reaches 0 after 2 frames.
REQ-030 SHALL pass this test: assert reset at b=20 with level=3. The next cycle shows SClk=LRClk=Dout=0 and level=0.
